// File: rtl/upcounter_rx_assembler.sv
// Pairs LSB/MSB bytes from the SPI slave into a validated 14-bit count for the display logic.
// Define UPCOUNTER_RX_BCD_EN to build the sequential double-dabble BCD converter.
module upcounter_rx_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned MAX_COUNT      = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_sync_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic [13:0] value_o,
  output logic        value_valid_o,
  output logic        err_format_o,
  output logic        err_range_o,
  output logic        err_timeout_o,
  output logic [15:0] bcd_o,
  output logic        bcd_valid_o
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerMax  = '1;
  localparam logic [13:0]       MaxCount  = 14'(MAX_COUNT);

  typedef enum logic [0:0] {StWaitLsb, StWaitMsb} state_e;

  state_e            state_q, state_d;
  logic [7:0]        lsb_q, lsb_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [13:0]       value_q, value_d;
  logic              value_valid_q, value_valid_d;
  logic              err_format_q, err_format_d;
  logic              err_range_q, err_range_d;
  logic              err_timeout_q, err_timeout_d;
  logic [13:0]       cand;

  // MSB carries count[13:8]; concatenation only, no carry between bytes.
  assign cand = {rx_data_i[5:0], lsb_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StWaitLsb;
      lsb_q         <= '0;
      timer_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_format_q  <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lsb_q         <= lsb_d;
      timer_q       <= timer_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_format_q  <= err_format_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lsb_d         = lsb_q;
    timer_d       = timer_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    err_format_d  = 1'b0;
    err_range_d   = 1'b0;
    err_timeout_d = 1'b0;

    if (frame_sync_i) begin
      // Frame start drops any pending LSB silently; a byte in the same cycle opens the new pair.
      timer_d = '0;
      if (rx_valid_i) begin
        lsb_d   = rx_data_i;
        state_d = StWaitMsb;
      end else begin
        lsb_d   = '0;
        state_d = StWaitLsb;
      end
    end else begin
      unique case (state_q)
        StWaitLsb: begin
          if (rx_valid_i) begin
            lsb_d   = rx_data_i;
            timer_d = '0;
            state_d = StWaitMsb;
          end
        end
        StWaitMsb: begin
          if (rx_valid_i) begin
            state_d = StWaitLsb;
            if (rx_data_i[7:6] != 2'b00) begin
              err_format_d = 1'b1;
            end else if (cand > MaxCount) begin
              err_range_d = 1'b1;
            end else begin
              value_d       = cand;
              value_valid_d = 1'b1;
            end
          end else if (timer_q == TimerLast) begin
            err_timeout_d = 1'b1;
            state_d       = StWaitLsb;
          end else if (timer_q != TimerMax) begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = StWaitLsb;
      endcase
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = value_valid_q;
  assign err_format_o  = err_format_q;
  assign err_range_o   = err_range_q;
  assign err_timeout_o = err_timeout_q;

  pulse_onehot_a: assert property (@(posedge clk) disable iff (reset)
    $onehot0({value_valid_q, err_format_q, err_range_q, err_timeout_q}));

`ifdef UPCOUNTER_RX_BCD_EN
  logic        busy_q, busy_d;
  logic [3:0]  iter_q, iter_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [15:0] acc_adj;
  logic [15:0] acc_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      iter_q      <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      iter_q      <= iter_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[14:0], shift_q[13]};
  end

  always_comb begin
    busy_d      = busy_q;
    iter_d      = iter_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;

    // A fresh value always restarts the conversion; bcd_q keeps the last finished result.
    if (value_valid_q) begin
      busy_d  = 1'b1;
      iter_d  = '0;
      shift_d = value_q;
      acc_d   = '0;
    end else if (busy_q) begin
      acc_d   = acc_shift;
      shift_d = {shift_q[12:0], 1'b0};
      iter_d  = iter_q + 4'd1;
      if (iter_q == 4'd13) begin
        busy_d      = 1'b0;
        bcd_d       = acc_shift;
        bcd_valid_d = 1'b1;
      end
    end
  end

  assign bcd_o       = bcd_q;
  assign bcd_valid_o = bcd_valid_q;
`else
  assign bcd_o       = 16'h0000;
  assign bcd_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_upcounter_rx_assembler.sv
// Directed scoreboard bench for upcounter_rx_assembler; stimulus queues expected pulses,
// a negedge monitor pops and compares them (BCD checks active when UPCOUNTER_RX_BCD_EN is set).
module tb_upcounter_rx_assembler;

  localparam int unsigned T = 20;
  localparam int KVal = 0, KFmt = 1, KRng = 2, KTmo = 3;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_sync = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [13:0] value;
  logic        value_valid, err_format, err_range, err_timeout;
  logic [15:0] bcd;
  logic        bcd_valid;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   value_model = 0;
  int   bcd_model = 0;
  ev_t  exp_q[$];
  ev_t  bcd_q[$];

  upcounter_rx_assembler #(
    .TIMEOUT_CYCLES(T),
    .MAX_COUNT     (9999)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_sync_i (frame_sync),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .value_o      (value),
    .value_valid_o(value_valid),
    .err_format_o (err_format),
    .err_range_o  (err_range),
    .err_timeout_o(err_timeout),
    .bcd_o        (bcd),
    .bcd_valid_o  (bcd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Drive one cycle of inputs starting just after a posedge; returns just after the next one.
  task automatic drive(input logic [7:0] b, input logic rv, input logic fs);
    rx_data    = b;
    rx_valid   = rv;
    frame_sync = fs;
    @(posedge clk);
    #1;
    rx_valid   = 1'b0;
    frame_sync = 1'b0;
    rx_data    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input int v, input int at);
    ev_t e;
    e.kind  = kind;
    e.value = v;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic send_pair(input logic [7:0] lsb, input logic [7:0] msb,
                           input int kind, input int v);
    drive(lsb, 1'b1, 1'b0);
    expect_ev(kind, v, cyc + 1);
    drive(msb, 1'b1, 1'b0);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      int n_ev;
      int kind_act;
      ev_t e;
      n_ev = int'(value_valid) + int'(err_format) + int'(err_range) + int'(err_timeout);
      if (n_ev > 1) check("pulse_onehot", n_ev, 1);
      if (n_ev != 0) begin
        kind_act = value_valid ? KVal : err_format ? KFmt : err_range ? KRng : KTmo;
        if (exp_q.size() == 0) begin
          check("unexpected_event_kind", kind_act, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind_act, e.kind);
          check("event_cycle", cyc, e.cyc);
          check("bcd_hold", int'(bcd), bcd_model);
          if (kind_act == KVal) begin
            check("value", int'(value), e.value);
            value_model = e.value;
`ifdef UPCOUNTER_RX_BCD_EN
            begin
              ev_t b;
              b.kind  = KVal;
              b.value = to_bcd(e.value);
              b.cyc   = cyc + 15;
              bcd_q.push_back(b);
            end
`endif
          end else begin
            check("value_hold", int'(value), value_model);
          end
        end
      end
      if (bcd_valid) begin
        if (bcd_q.size() == 0) begin
          check("unexpected_bcd_valid", int'(bcd), -1);
        end else begin
          e = bcd_q.pop_front();
          check("bcd", int'(bcd), e.value);
          check("bcd_cycle", cyc, e.cyc);
          bcd_model = e.value;
        end
      end
    end
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", int'(value), 0);
    check("reset_pulses", int'({value_valid, err_format, err_range, err_timeout, bcd_valid}), 0);
    check("reset_bcd", int'(bcd), 0);
    reset = 1'b0;
    idle(2);

    // 9999 accepted; 10000 rejected with value held.
    send_pair(8'h0F, 8'h27, KVal, 9999);
    idle(20);
    send_pair(8'h10, 8'h27, KRng, 0);
    idle(20);

    // Format error, then a clean pair.
    send_pair(8'h34, 8'h52, KFmt, 0);
    idle(3);
    send_pair(8'h01, 8'h00, KVal, 1);
    idle(20);

    // Timeout after exactly T cycles in WAIT_MSB, next byte is an LSB.
    drive(8'h33, 1'b1, 1'b0);
    c = cyc - 1;
    expect_ev(KTmo, 0, c + T + 1);
    idle(T + 5);
    send_pair(8'h09, 8'h00, KVal, 9);
    idle(20);

    // MSB arriving on the last timer cycle wins over the timeout.
    drive(8'h0A, 1'b1, 1'b0);
    idle(T - 1);
    expect_ev(KVal, 266, cyc + 1);
    drive(8'h01, 1'b1, 1'b0);
    idle(20);

    // frame_sync alone discards the pending LSB.
    drive(8'hAA, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
    send_pair(8'h05, 8'h00, KVal, 5);
    idle(20);

    // frame_sync with a byte: that byte starts the new pair.
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b1);
    expect_ev(KVal, 34, cyc + 1);
    drive(8'h00, 1'b1, 1'b0);
    idle(20);

    // Reset in WAIT_MSB: everything clears, next byte is an LSB.
    drive(8'h44, 1'b1, 1'b0);
    idle(2);
    reset = 1'b1;
    #1;
    check("midreset_value", int'(value), 0);
    check("midreset_bcd", int'(bcd), 0);
    check("midreset_pulses", int'({value_valid, err_format, err_range, err_timeout, bcd_valid}), 0);
    value_model = 0;
    bcd_model   = 0;
    idle(2);
    reset = 1'b0;
    idle(1);
    send_pair(8'h07, 8'h00, KVal, 7);
    idle(30);

    check("pending_events", exp_q.size(), 0);
    check("pending_bcd", bcd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
